// File: rtl/posit_mult_pkg.sv
// Shared types and helpers for the posit multiplier scheduler.
package posit_mult_pkg;

  localparam int P_WIDTH = 8;
  localparam int P_NREQ  = 4;
  localparam int P_IDW   = $clog2(P_NREQ);

  typedef logic [P_IDW-1:0] id_t;

  // One response FIFO entry: who asked, and what came back.
  typedef struct packed {
    id_t                id;
    logic [P_WIDTH-1:0] res;
  } rsp_t;

  // One tag pipe stage: an op is in flight at this depth, and whose it is.
  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  // Round-robin pointer after a grant to `cur`: the requester just past the winner.
  function automatic id_t rr_next(input id_t cur, input int unsigned nreq);
    if (int'(cur) >= int'(nreq) - 1) return '0;
    return cur + id_t'(1);
  endfunction

endpackage

// File: rtl/posit_mult_rsp_fifo.sv
// First-word fall-through response FIFO with an occupancy count.
// Push and pop in the same cycle are fine at any fill level. The caller
// guarantees it never pushes into a full FIFO.
module posit_mult_rsp_fifo
  import posit_mult_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNTW  = $clog2(DEPTH + 1),
  localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk_i,
  input  logic            rstn,
  input  logic            push_i,
  input  rsp_t            push_data_i,
  input  logic            pop_i,
  output logic            empty_o,
  output rsp_t            head_o,
  output logic [CNTW-1:0] count_o
);

  rsp_t            mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTRW'(1);
  endfunction

  // Pointer and occupancy next state.
  always_comb begin
    // NOTE: every variable gets a value before any condition, so no latch can be inferred.
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d  = count_q + CNTW'(push_i) - CNTW'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rstn) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset. Nothing reads an entry before it is written, and the head is gated while empty.
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/posit_mult_sched.sv
// Shares one fixed-latency posit multiplier among NREQ requesters.
// Requesters are served round-robin. Operands are registered into the multiplier,
// and requester IDs ride a tag pipe that lines up with the multiplier results.
// Results are buffered in a response FIFO. A credit counter guarantees the FIFO
// never overflows, so the multiplier never has to stall.
// Optional feature macro: POSIT_MULT_SCHED_PERF_EN adds saturating issue and stall counters.
module posit_mult_sched
  import posit_mult_pkg::*;
#(
  parameter  int WIDTH = P_WIDTH,
  parameter  int NREQ  = P_NREQ,
  parameter  int LAT   = 3,
  parameter  int DEPTH = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_vld_i,
  output logic [NREQ-1:0]       req_rdy_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  mul_vld_o,
  output logic [WIDTH-1:0]      mul_a_o,
  output logic [WIDTH-1:0]      mul_b_o,
  input  logic                  mul_vld_i,
  input  logic [WIDTH-1:0]      mul_res_i,
  output logic                  rsp_vld_o,
  input  logic                  rsp_rdy_i,
  output logic [IDW-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]      rsp_res_o,
  output logic                  busy_o,
`ifdef POSIT_MULT_SCHED_PERF_EN
  output logic [31:0]           perf_issue_o,
  output logic [31:0]           perf_stall_o,
`endif
  output logic                  err_o
);

  localparam int CW = $clog2(DEPTH + 1);

  id_t              ptr_q, ptr_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic             mul_vld_q, mul_vld_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  tag_t             tag_q [LAT+1];
  tag_t             tag_d [LAT+1];
  logic             err_q, err_d;

  logic             grant_vld;
  id_t              grant_id;
  logic [NREQ-1:0]  grant_oh;
  int               idx;
  logic             pipe_push, pipe_mismatch, pop, tag_any;
  rsp_t             push_data, head;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  // Arbitration: first valid requester at or after the pointer, while credits remain.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    idx       = 0;
    if (credits_q != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = (int'(ptr_q) + i) % NREQ;
        if (!grant_vld && req_vld_i[idx]) begin
          grant_vld = 1'b1;
          grant_id  = id_t'(idx);
        end
      end
    end
    if (grant_vld) grant_oh[grant_id] = 1'b1;
  end

  assign pop = rsp_vld_o & rsp_rdy_i;

  // Pointer, issue register, tag pipe, credits and error next state.
  always_comb begin
    ptr_d     = grant_vld ? rr_next(grant_id, NREQ) : ptr_q;
    mul_vld_d = grant_vld;
    mul_a_d   = grant_vld ? req_a_i[int'(grant_id)*WIDTH +: WIDTH] : mul_a_q;
    mul_b_d   = grant_vld ? req_b_i[int'(grant_id)*WIDTH +: WIDTH] : mul_b_q;

    tag_d[0] = '{vld: grant_vld, id: grant_id};
    for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];

    // The last tag stage is in step with the multiplier's result valid.
    pipe_mismatch = tag_q[LAT].vld ^ mul_vld_i;
    pipe_push     = tag_q[LAT].vld & mul_vld_i;
    push_data     = '{id: tag_q[LAT].id, res: mul_res_i};

    err_d     = err_q | pipe_mismatch;
    credits_d = credits_q - CW'(grant_vld) + CW'(pop);

    tag_any = 1'b0;
    for (int k = 0; k <= LAT; k++) tag_any = tag_any | tag_q[k].vld;
  end

  // Scheduler state registers.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      ptr_q     <= '0;
      credits_q <= CW'(DEPTH);
      mul_vld_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      mul_vld_q <= mul_vld_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      err_q     <= err_d;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  posit_mult_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rstn        (rstn),
    .push_i      (pipe_push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .empty_o     (fifo_empty),
    .head_o      (head),
    .count_o     (fifo_count)
  );

`ifdef POSIT_MULT_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating counts of grants, and of cycles with requests pending but no grant.
  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    if (grant_vld && (perf_issue_q != '1)) perf_issue_d = perf_issue_q + 32'd1;
    if ((|req_vld_i) && !grant_vld && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_o = perf_issue_q;
  assign perf_stall_o = perf_stall_q;
`endif

  assign req_rdy_o = grant_oh;
  assign mul_vld_o = mul_vld_q;
  assign mul_a_o   = mul_a_q;
  assign mul_b_o   = mul_b_q;
  assign rsp_vld_o = !fifo_empty;
  assign rsp_id_o  = head.id;
  assign rsp_res_o = head.res;
  assign busy_o    = mul_vld_q | tag_any | (fifo_count != '0);
  assign err_o     = err_q;

endmodule

// File: tb/tb_posit_mult_sched.sv
// Self-checking bench for posit_mult_sched. It holds a multiplier model with
// fixed latency and a transaction-level reference: grant order, an outstanding
// count and an in-order expected-response queue.
module tb_posit_mult_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic                  clk_i = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req_vld_i;
  logic [NREQ-1:0]       req_rdy_o;
  logic [NREQ*WIDTH-1:0] req_a_i, req_b_i;
  logic                  mul_vld_o;
  logic [WIDTH-1:0]      mul_a_o, mul_b_o;
  logic                  mul_vld_i;
  logic [WIDTH-1:0]      mul_res_i;
  logic                  rsp_vld_o, rsp_rdy_i;
  logic [IDW-1:0]        rsp_id_o;
  logic [WIDTH-1:0]      rsp_res_o;
  logic                  busy_o, err_o;
`ifdef POSIT_MULT_SCHED_PERF_EN
  logic [31:0]           perf_issue_o, perf_stall_o;
`endif

  posit_mult_sched #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i     (clk_i),
    .rstn      (rstn),
    .req_vld_i (req_vld_i),
    .req_rdy_o (req_rdy_o),
    .req_a_i   (req_a_i),
    .req_b_i   (req_b_i),
    .mul_vld_o (mul_vld_o),
    .mul_a_o   (mul_a_o),
    .mul_b_o   (mul_b_o),
    .mul_vld_i (mul_vld_i),
    .mul_res_i (mul_res_i),
    .rsp_vld_o (rsp_vld_o),
    .rsp_rdy_i (rsp_rdy_i),
    .rsp_id_o  (rsp_id_o),
    .rsp_res_o (rsp_res_o),
    .busy_o    (busy_o),
`ifdef POSIT_MULT_SCHED_PERF_EN
    .perf_issue_o (perf_issue_o),
    .perf_stall_o (perf_stall_o),
`endif
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] res;
  } exp_t;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference state
  int               ptr_m;
  int               outstanding;
  exp_t             exp_q[$];
  logic             prev_vld;
  logic [WIDTH-1:0] last_a, last_b;
  logic             err_m;
  logic             drop_next;
  logic             drop_seen;
  int               cyc;
  int               grant_cnt;
  int               gl_id[$];
  int               gl_cyc[$];

  // Multiplier model pipeline
  logic             mv [LAT];
  logic [WIDTH-1:0] mr [LAT];

  // Stand-in multiply: any deterministic function works for a forwarding check. 0x40 (1.0) times 0x40 gives 0x40.
  function automatic logic [WIDTH-1:0] mulf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a ^ b ^ 8'h40;
  endfunction

  task automatic clear_model();
    ptr_m = 0; outstanding = 0; exp_q.delete();
    prev_vld = 1'b0; last_a = '0; last_b = '0;
    err_m = 1'b0; drop_next = 1'b0; drop_seen = 1'b0;
    for (int k = 0; k < LAT; k++) begin mv[k] = 1'b0; mr[k] = '0; end
    mul_vld_i = 1'b0; mul_res_i = '0;
  endtask

  // Asynchronous reset; outputs are checked while the reset is still asserted. Returns just after a negedge.
  task automatic apply_reset();
    req_vld_i = '0; rsp_rdy_i = 1'b0;
    rstn = 1'b0;
    clear_model();
    #2;
    total_cnt++;
    if ({req_rdy_o, mul_vld_o, mul_a_o, mul_b_o, rsp_vld_o, rsp_id_o, rsp_res_o, busy_o, err_o} !== '0) begin
      $display("FAIL reset_outputs: rdy=%b mvld=%b a=%h b=%h rvld=%b id=%0d res=%h busy=%b err=%b, all required 0",
               req_rdy_o, mul_vld_o, mul_a_o, mul_b_o, rsp_vld_o, rsp_id_o, rsp_res_o, busy_o, err_o);
    end else pass_cnt++;
    @(negedge clk_i);
    rstn = 1'b1;
  endtask

  // One clock cycle: multiplier model, reference checks, then advance to the next negedge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int win;
    int busy_exp;
    busy_exp = (outstanding != 0);
    mul_vld_i = mv[LAT-1];
    mul_res_i = mr[LAT-1];
    if (drop_next && mv[LAT-1]) begin
      mul_vld_i = 1'b0;
      drop_next = 1'b0;
      drop_seen = 1'b1;
    end
    for (int k = LAT-1; k > 0; k--) begin mv[k] = mv[k-1]; mr[k] = mr[k-1]; end
    mv[0] = mul_vld_o;
    mr[0] = mulf(mul_a_o, mul_b_o);
    #1;

    exp_rdy = '0;
    win = -1;
    if (outstanding < DEPTH) begin
      for (int i = 0; i < NREQ; i++) begin
        int k = (ptr_m + i) % NREQ;
        if (win < 0 && req_vld_i[k]) win = k;
      end
    end
    if (win >= 0) exp_rdy[win] = 1'b1;

    total_cnt++;
    if (req_rdy_o !== exp_rdy) $display("FAIL grant @%0d: got %b want %b", cyc, req_rdy_o, exp_rdy);
    else pass_cnt++;

    total_cnt++;
    if (mul_vld_o !== prev_vld || mul_a_o !== last_a || mul_b_o !== last_b)
      $display("FAIL issue @%0d: got vld=%b a=%h b=%h want vld=%b a=%h b=%h",
               cyc, mul_vld_o, mul_a_o, mul_b_o, prev_vld, last_a, last_b);
    else pass_cnt++;

    total_cnt++;
    if (err_o !== err_m) $display("FAIL err @%0d: got %b want %b", cyc, err_o, err_m);
    else pass_cnt++;

    if (!err_m) begin
      total_cnt++;
      if (busy_o !== busy_exp[0]) $display("FAIL busy @%0d: got %b want %b", cyc, busy_o, busy_exp[0]);
      else pass_cnt++;
    end

    if (rsp_vld_o && rsp_rdy_i) begin
      total_cnt++;
      if (exp_q.size() == 0) $display("FAIL rsp_extra @%0d: got id=%0d res=%h want none", cyc, rsp_id_o, rsp_res_o);
      else if (rsp_id_o !== exp_q[0].id || rsp_res_o !== exp_q[0].res)
        $display("FAIL rsp @%0d: got id=%0d res=%h want id=%0d res=%h",
                 cyc, rsp_id_o, rsp_res_o, exp_q[0].id, exp_q[0].res);
      else pass_cnt++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      outstanding--;
    end

    if (drop_seen) err_m = 1'b1;
    prev_vld = (win >= 0);
    if (win >= 0) begin
      exp_t e;
      last_a = req_a_i[win*WIDTH +: WIDTH];
      last_b = req_b_i[win*WIDTH +: WIDTH];
      e.id   = IDW'(win);
      e.res  = mulf(last_a, last_b);
      exp_q.push_back(e);
      outstanding++;
      grant_cnt++;
      ptr_m = (win + 1) % NREQ;
      gl_id.push_back(win);
      gl_cyc.push_back(cyc);
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic drain();
    req_vld_i = '0;
    rsp_rdy_i = 1'b1;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || busy_o); i++) step();
    total_cnt++;
    if (exp_q.size() != 0 || busy_o !== 1'b0)
      $display("FAIL drain: %0d responses outstanding, busy=%b, want 0 and 0", exp_q.size(), busy_o);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    apply_reset();
    step();
  endtask

  task automatic test_single();
    bit found;
    apply_reset();
    req_a_i = $urandom(); req_b_i = $urandom();
    req_a_i[2*WIDTH +: WIDTH] = 8'h40;
    req_b_i[2*WIDTH +: WIDTH] = 8'h40;
    req_vld_i = 4'b0100;
    rsp_rdy_i = 1'b1;
    step();
    req_vld_i = '0;
    total_cnt++;
    if (mul_vld_o !== 1'b1 || mul_a_o !== 8'h40 || mul_b_o !== 8'h40)
      $display("FAIL single_issue: got vld=%b a=%h b=%h want 1 40 40", mul_vld_o, mul_a_o, mul_b_o);
    else pass_cnt++;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_vld_o) begin found = 1'b1; break; end
      step();
    end
    total_cnt++;
    if (!found || rsp_id_o !== 2'd2 || rsp_res_o !== 8'h40)
      $display("FAIL single_rsp: got seen=%b id=%0d res=%h want 1 2 40", found, rsp_id_o, rsp_res_o);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_round_robin();
    int base;
    apply_reset();
    base = gl_id.size();
    req_vld_i = '1;
    rsp_rdy_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      req_a_i = $urandom(); req_b_i = $urandom();
      step();
    end
    for (int j = 0; j < 4; j++) begin
      total_cnt++;
      if (gl_id[base+j] != j || gl_cyc[base+j] != gl_cyc[base] + j)
        $display("FAIL rr_first: grant %0d got id=%0d cyc=%0d want id=%0d cyc=%0d",
                 j, gl_id[base+j], gl_cyc[base+j], j, gl_cyc[base] + j);
      else pass_cnt++;
    end
    for (int j = base + 1; j < gl_id.size(); j++) begin
      total_cnt++;
      if (gl_id[j] != (gl_id[j-1] + 1) % NREQ)
        $display("FAIL rr_order: grant %0d got id=%0d want %0d", j, gl_id[j], (gl_id[j-1] + 1) % NREQ);
      else pass_cnt++;
    end
    drain();
  endtask

  task automatic test_credit_block();
    int g0;
    apply_reset();
    g0 = grant_cnt;
    req_vld_i = '1;
    rsp_rdy_i = 1'b0;
    req_a_i = $urandom(); req_b_i = $urandom();
    for (int i = 0; i < 12; i++) step();
    total_cnt++;
    if (grant_cnt - g0 != DEPTH || req_rdy_o !== '0)
      $display("FAIL credit_block: got %0d grants rdy=%b want %0d grants rdy=0000", grant_cnt - g0, req_rdy_o, DEPTH);
    else pass_cnt++;
    rsp_rdy_i = 1'b1;
    g0 = grant_cnt;
    step();
    total_cnt++;
    if (grant_cnt != g0) $display("FAIL credit_pop_cycle: got %0d grants want 0", grant_cnt - g0);
    else pass_cnt++;
    step();
    total_cnt++;
    if (grant_cnt != g0 + 1) $display("FAIL credit_return: got %0d grants want 1", grant_cnt - g0);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_fifo_push_pop();
    apply_reset();
    req_vld_i = '1;
    for (int i = 0; i < 40; i++) begin
      req_a_i = $urandom(); req_b_i = $urandom();
      rsp_rdy_i = i[0];
      step();
    end
    drain();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      req_vld_i = NREQ'($urandom());
      req_a_i   = $urandom();
      req_b_i   = $urandom();
      rsp_rdy_i = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
  endtask

  task automatic test_err();
    apply_reset();
    req_a_i = $urandom(); req_b_i = $urandom();
    req_vld_i = 4'b0001;
    rsp_rdy_i = 1'b1;
    step();
    req_vld_i = '0;
    drop_next = 1'b1;
    for (int i = 0; i < 12 && !drop_seen; i++) step();
    total_cnt++;
    if (!drop_seen || err_o !== 1'b1)
      $display("FAIL err_set: got dropped=%b err=%b want 1 1", drop_seen, err_o);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) step();
    total_cnt++;
    if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o);
    else pass_cnt++;
    apply_reset();
    step();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    req_vld_i = '1;
    rsp_rdy_i = 1'b1;
    req_a_i = $urandom(); req_b_i = $urandom();
    step(); step(); step();
    apply_reset();
    req_vld_i = '1;
    #1;
    total_cnt++;
    if (req_rdy_o !== 4'b0001) $display("FAIL reset_next_grant: got %b want 0001", req_rdy_o);
    else pass_cnt++;
    step(); step();
    drain();
  endtask

  initial begin
    rstn = 1'b0;
    req_vld_i = '0; req_a_i = '0; req_b_i = '0; rsp_rdy_i = 1'b0;
    mul_vld_i = 1'b0; mul_res_i = '0;
    cyc = 0; grant_cnt = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_credit_block();
    test_fifo_push_pop();
    test_random();
    test_err();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
